// File: rtl/cnn_pkg.sv
// Shared helpers for the CNN pipeline stages: counter-width sizing and unsigned max.
package cnn_pkg;

    // Widest pixel the shared max() helper handles; callers size-cast in and out.
    localparam int unsigned MaxDataWidth = 32;

    // Bits needed to count 0..n-1 (at least one bit).
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // Unsigned maximum; on a tie either operand is equivalent.
    function automatic logic [MaxDataWidth-1:0] max_u(input logic [MaxDataWidth-1:0] a,
                                                      input logic [MaxDataWidth-1:0] b);
        return (a >= b) ? a : b;
    endfunction

endpackage

// File: rtl/max_pool_if.sv
// Pixel stream into and pooled stream out of the max_pool stage.
interface max_pool_if #(
    parameter int unsigned DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] input_stream;
    logic                  input_valid;
    logic                  input_first;
    logic [DATA_WIDTH-1:0] output_stream;
    logic                  output_valid;
    logic                  output_first;
    logic                  output_last;

    // Upstream/testbench side: drives pixels, observes pooled results.
    modport master (
        output input_stream, input_valid, input_first,
        input  output_stream, output_valid, output_first, output_last
    );

    // Pooling stage side.
    modport slave (
        input  input_stream, input_valid, input_first,
        output output_stream, output_valid, output_first, output_last
    );
endinterface

// File: rtl/pool_line_buffer.sv
// Half-row line buffer: one write port, one synchronous read port, no reset.
module pool_line_buffer #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned ADDR_WIDTH = 2
) (
    input  logic                  clk_i,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic                  re_i,
    input  logic [ADDR_WIDTH-1:0] raddr_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

    // Read data is held until the next read so input gaps cannot disturb it.
    always_comb begin
        rdata_d = rdata_q;
        if (re_i) rdata_d = mem[raddr_i];
    end

    // Storage and read register (no reset keeps it RAM-inferable).
    always_ff @(posedge clk_i) begin
        if (we_i) mem[waddr_i] <= wdata_i;
        rdata_q <= rdata_d;
    end

    assign rdata_o = rdata_q;
endmodule

// File: rtl/max_pool.sv
// Streaming 2x2 stride-2 max pooling over a raster-order unsigned pixel stream.
module max_pool
    import cnn_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = 8,
    parameter int unsigned IMAGE_WIDTH  = 8,
    parameter int unsigned IMAGE_HEIGHT = 8
) (
    input logic       clk,
    input logic       rst_n,
    max_pool_if.slave bus
);
    localparam int unsigned ColW  = cnt_width(IMAGE_WIDTH);
    localparam int unsigned RowW  = cnt_width(IMAGE_HEIGHT);
    localparam int unsigned Depth = IMAGE_WIDTH / 2;
    localparam int unsigned AddrW = cnt_width(Depth);

    logic [ColW-1:0]       col_q, col_d, cur_col;
    logic [RowW-1:0]       row_q, row_d, cur_row;
    logic [DATA_WIDTH-1:0] h_hold_q, h_hold_d;
    logic [DATA_WIDTH-1:0] out_stream_q, out_stream_d;
    logic                  out_valid_q, out_valid_d;
    logic                  out_first_q, out_first_d;
    logic                  out_last_q, out_last_d;
    logic [DATA_WIDTH-1:0] hmax, pool, lb_rdata;
    logic                  lb_we, lb_re;
    logic [AddrW-1:0]      lb_addr;

    // Position of the incoming pixel; input_first forces row 0 col 0.
    always_comb begin
        cur_col = col_q;
        cur_row = row_q;
        if (bus.input_valid && bus.input_first) begin
            cur_col = '0;
            cur_row = '0;
        end
    end

    // Horizontal max of the pair and vertical max against the stored even-row result.
    always_comb begin
        hmax    = DATA_WIDTH'(max_u(MaxDataWidth'(h_hold_q), MaxDataWidth'(bus.input_stream)));
        pool    = DATA_WIDTH'(max_u(MaxDataWidth'(lb_rdata), MaxDataWidth'(hmax)));
        lb_addr = AddrW'(cur_col >> 1);
        lb_re   = bus.input_valid && !cur_col[0];
        lb_we   = bus.input_valid && cur_col[0] && !cur_row[0];
    end

    // Counter advance, pair hold and output register next-state.
    always_comb begin
        col_d        = col_q;
        row_d        = row_q;
        h_hold_d     = h_hold_q;
        out_stream_d = out_stream_q;
        out_valid_d  = 1'b0;
        out_first_d  = 1'b0;
        out_last_d   = 1'b0;
        if (bus.input_valid) begin
            if (cur_col == ColW'(IMAGE_WIDTH - 1)) begin
                col_d = '0;
                row_d = (cur_row == RowW'(IMAGE_HEIGHT - 1)) ? '0 : cur_row + RowW'(1);
            end else begin
                col_d = cur_col + ColW'(1);
                row_d = cur_row;
            end
            if (!cur_col[0]) begin
                h_hold_d = bus.input_stream;
            end else if (cur_row[0]) begin
                out_stream_d = pool;
                out_valid_d  = 1'b1;
                out_first_d  = (cur_row == RowW'(1)) && (cur_col == ColW'(1));
                out_last_d   = (cur_row == RowW'(IMAGE_HEIGHT - 1)) &&
                               (cur_col == ColW'(IMAGE_WIDTH - 1));
            end
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q        <= '0;
            row_q        <= '0;
            h_hold_q     <= '0;
            out_stream_q <= '0;
            out_valid_q  <= 1'b0;
            out_first_q  <= 1'b0;
            out_last_q   <= 1'b0;
        end else begin
            col_q        <= col_d;
            row_q        <= row_d;
            h_hold_q     <= h_hold_d;
            out_stream_q <= out_stream_d;
            out_valid_q  <= out_valid_d;
            out_first_q  <= out_first_d;
            out_last_q   <= out_last_d;
        end
    end

    pool_line_buffer #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (Depth),
        .ADDR_WIDTH (AddrW)
    ) u_line_buffer (
        .clk_i   (clk),
        .we_i    (lb_we),
        .waddr_i (lb_addr),
        .wdata_i (hmax),
        .re_i    (lb_re),
        .raddr_i (lb_addr),
        .rdata_o (lb_rdata)
    );

    assign bus.output_stream = out_stream_q;
    assign bus.output_valid  = out_valid_q;
    assign bus.output_first  = out_first_q;
    assign bus.output_last   = out_last_q;
endmodule

// File: tb/tb_max_pool.sv
// Self-checking bench for max_pool (4x4 frames) against a frame-array window model.
module tb_max_pool;
    localparam int W = 4;
    localparam int H = 4;
    localparam int N = W * H;

    typedef logic [7:0] frame_t [N];
    typedef struct {
        logic [7:0] a, b, c, d;
        logic [7:0] exp;
    } win_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    max_pool_if #(.DATA_WIDTH(8)) bus ();

    max_pool #(
        .DATA_WIDTH   (8),
        .IMAGE_WIDTH  (W),
        .IMAGE_HEIGHT (H)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: the current frame as a plain array plus a raster index.
    int         img [N];
    int         idx;
    logic [7:0] exp_stream;
    logic       exp_valid, exp_first, exp_last;
    int         outs[$];
    int         want[$];
    int         n_first, n_last;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    task automatic model_reset();
        idx = 0;
        exp_stream = 8'd0;
        exp_valid = 1'b0;
        exp_first = 1'b0;
        exp_last = 1'b0;
    endtask

    task automatic model_accept(input logic v, input logic [7:0] d, input logic f);
        int r, c;
        exp_valid = 1'b0;
        exp_first = 1'b0;
        exp_last = 1'b0;
        if (v) begin
            if (f) idx = 0;
            img[idx] = int'(d);
            r = idx / W;
            c = idx % W;
            if ((r % 2 == 1) && (c % 2 == 1)) begin
                exp_stream = 8'(max2(max2(img[(r-1)*W + c-1], img[(r-1)*W + c]),
                                     max2(img[r*W + c-1], img[r*W + c])));
                exp_valid = 1'b1;
                exp_first = (idx == W + 1);
                exp_last = (idx == N - 1);
            end
            idx = (idx + 1) % N;
        end
    endtask

    task automatic check_outputs(input string name);
        checks++;
        if (bus.output_stream !== exp_stream || bus.output_valid !== exp_valid ||
            bus.output_first !== exp_first || bus.output_last !== exp_last) begin
            errors++;
            $display("FAIL %s: got stream=%0d v=%b f=%b l=%b, want stream=%0d v=%b f=%b l=%b",
                     name, bus.output_stream, bus.output_valid, bus.output_first,
                     bus.output_last, exp_stream, exp_valid, exp_first, exp_last);
        end
        if (bus.output_valid === 1'b1) begin
            outs.push_back(int'(bus.output_stream));
            if (bus.output_first === 1'b1) n_first++;
            if (bus.output_last === 1'b1) n_last++;
        end
    endtask

    task automatic expect_eq(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d", name, got, exp);
        end
    endtask

    // One clock: check last cycle's prediction, then apply new inputs.
    task automatic step(input logic v, input logic [7:0] d, input logic f);
        @(negedge clk);
        check_outputs("cycle");
        bus.input_valid = v;
        bus.input_stream = d;
        bus.input_first = f;
        model_accept(v, d, f);
    endtask

    task automatic send_pixels(input frame_t pix, input int from, input int to,
                               input logic first, input int max_gap);
        for (int i = from; i <= to; i++) begin
            repeat ($urandom_range(max_gap, 0)) step(1'b0, 8'($urandom), 1'($urandom));
            step(1'b1, pix[i], first && (i == from));
        end
    endtask

    task automatic flush();
        repeat (3) step(1'b0, 8'd0, 1'b0);
    endtask

    task automatic check_outs(input string name);
        expect_eq({name, "_count"}, outs.size(), want.size());
        for (int i = 0; i < want.size() && i < outs.size(); i++)
            expect_eq($sformatf("%s_out%0d", name, i), outs[i], want[i]);
    endtask

    task automatic clear_log();
        outs.delete();
        n_first = 0;
        n_last = 0;
    endtask

    frame_t ramp, pix;
    win_t   tbl [6];

    initial begin
        bus.input_valid = 1'b0;
        bus.input_stream = 8'd0;
        bus.input_first = 1'b0;
        model_reset();
        for (int i = 0; i < N; i++) ramp[i] = 8'(i);
        tbl[0] = '{a: 8'd255, b: 8'd128, c: 8'd127, d: 8'd0,   exp: 8'd255};
        tbl[1] = '{a: 8'd42,  b: 8'd42,  c: 8'd42,  d: 8'd42,  exp: 8'd42};
        tbl[2] = '{a: 8'd0,   b: 8'd0,   c: 8'd0,   d: 8'd1,   exp: 8'd1};
        tbl[3] = '{a: 8'd3,   b: 8'd9,   c: 8'd2,   d: 8'd7,   exp: 8'd9};
        tbl[4] = '{a: 8'd1,   b: 8'd0,   c: 8'd0,   d: 8'd0,   exp: 8'd1};
        tbl[5] = '{a: 8'd0,   b: 8'd0,   c: 8'd200, d: 8'd0,   exp: 8'd200};

        // Reset state.
        @(negedge clk);
        check_outputs("reset");
        rst_n = 1'b1;
        clear_log();

        // Continuous ramp frame, then the same with random gaps.
        want = '{5, 7, 13, 15};
        send_pixels(ramp, 0, N - 1, 1'b1, 0);
        flush();
        check_outs("ramp");
        expect_eq("ramp_first", n_first, 1);
        expect_eq("ramp_last", n_last, 1);
        clear_log();
        send_pixels(ramp, 0, N - 1, 1'b1, 3);
        flush();
        check_outs("gaps");
        expect_eq("gaps_first", n_first, 1);
        expect_eq("gaps_last", n_last, 1);

        // Table of single-window value patterns (window 0 of a zero frame).
        for (int k = 0; k < 6; k++) begin
            clear_log();
            for (int i = 0; i < N; i++) pix[i] = 8'd0;
            pix[0] = tbl[k].a;
            pix[1] = tbl[k].b;
            pix[W] = tbl[k].c;
            pix[W + 1] = tbl[k].d;
            send_pixels(pix, 0, N - 1, 1'b1, 1);
            flush();
            expect_eq($sformatf("tbl%0d_count", k), outs.size(), 4);
            if (outs.size() > 0) expect_eq($sformatf("tbl%0d_win0", k), outs[0], int'(tbl[k].exp));
        end

        // Resync at row 2 col 1: partial frame drops, new frame pools normally.
        clear_log();
        want = '{5, 7, 5, 7, 13, 15};
        send_pixels(ramp, 0, 8, 1'b1, 0);
        send_pixels(ramp, 0, N - 1, 1'b1, 0);
        flush();
        check_outs("resync");
        expect_eq("resync_last", n_last, 1);

        // Asynchronous reset during row 1, then a fresh frame without input_first.
        clear_log();
        send_pixels(ramp, 0, 6, 1'b1, 0);
        #2;
        rst_n = 1'b0;
        bus.input_valid = 1'b0;
        #1;
        expect_eq("rst_async_stream", int'(bus.output_stream), 0);
        expect_eq("rst_async_valid", int'(bus.output_valid), 0);
        expect_eq("rst_async_first", int'(bus.output_first), 0);
        expect_eq("rst_async_last", int'(bus.output_last), 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        send_pixels(ramp, 0, N - 1, 1'b0, 0);
        flush();
        want = '{5, 5, 7, 13, 15};
        check_outs("after_rst");

        // Two back-to-back random frames, no input_first on the second.
        clear_log();
        for (int f = 0; f < 2; f++) begin
            for (int i = 0; i < N; i++) pix[i] = 8'($urandom);
            send_pixels(pix, 0, N - 1, (f == 0), 0);
        end
        flush();
        expect_eq("b2b_count", outs.size(), 8);
        expect_eq("b2b_first", n_first, 2);
        expect_eq("b2b_last", n_last, 2);

        // Random stream with gaps and occasional resyncs; model checks every cycle.
        for (int k = 0; k < 600; k++) begin
            logic v;
            v = ($urandom_range(3, 0) != 0);
            step(v, 8'($urandom), v && ($urandom_range(40, 0) == 0));
        end
        flush();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
